fp_mul_result_fifo: RTL and testbench

//  Downstream stage of the single-precision floating-point multiplier: captures each
//  {result, overflow} pair with a valid/ready handshake, sanitises and classifies it,
//  and buffers it in a small FIFO for the consumer (accumulator or writeback).

---
 rtl/fp_mul_result_fifo_if.sv | 22 ++
 rtl/fp_mul_result_fifo.sv | 104 ++++++++++
 tb/tb_fp_mul_result_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_result_fifo_if.sv
// Handshake bundle between the FP multiplier, the result FIFO and its consumer.
// The FIFO takes the slave side; the multiplier/consumer environment takes the master side.
interface fp_mul_result_fifo_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_result, in_overflow, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_result, in_overflow, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp_mul_result_fifo.sv
// Result FIFO behind the FP multiplier: sanitises and classifies each product,
// buffers it for the consumer and tracks sticky/saturating overflow statistics.
module fp_mul_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fp_mul_result_fifo_if.slave      bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_sticky,
  output logic [CNT_W-1:0]         ovf_count,
  input  logic                     clr_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [2:0]  flags;  // [0] zero, [1] overflow, [2] flushed subnormal
    logic [31:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               ready_en;
  logic               push;
  logic               pop;
  entry_t             wr_entry;

  function automatic entry_t sanitise(input logic [31:0] r, input logic ovf);
    entry_t e;
    e.data  = r;
    e.flags = 3'b000;
    if (ovf) begin
      e.data  = {r[31], 8'hFF, 23'h0};
      e.flags = 3'b010;
    end else if (r[30:23] == 8'h00 && r[22:0] != 23'h0) begin
      e.data  = {r[31], 31'h0};
      e.flags = 3'b101;
    end else if (r[30:23] == 8'h00) begin
      e.flags = 3'b001;
    end
    return e;
  endfunction

  // ready_en holds in_ready low during reset and for the reset-release cycle.
  assign bus.in_ready  = ready_en && (count < FULL_CNT);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign wr_entry      = sanitise(bus.in_result, bus.in_overflow);

  always_comb begin
    // NOTE: defaults first in every always_comb so no path can infer a latch.
    bus.out_data  = '0;
    bus.out_flags = '0;
    if (bus.out_valid) begin
      bus.out_data  = mem[rd_ptr].data;
      bus.out_flags = mem[rd_ptr].flags;
    end
  end

  // NOTE: storage is not reset; out_valid gating keeps stale contents invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An overflow push in the same cycle as clr_sticky restarts the statistics at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (push && bus.in_overflow) begin
      ovf_sticky <= 1'b1;
      if (clr_sticky)            ovf_count <= CNT_W'(1);
      else if (ovf_count != '1)  ovf_count <= ovf_count + 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_fp_mul_result_fifo.sv
// Directed bench for fp_mul_result_fifo (DEPTH=4, CNT_W=2): sanitising, ordering,
// full/wrap behaviour, overflow statistics and asynchronous reset.
module tb_fp_mul_result_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_sticky = 1'b0;
  logic [2:0] count;
  logic       ovf_sticky;
  logic [1:0] ovf_count;
  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         total = 0;

  fp_mul_result_fifo_if bus ();

  fp_mul_result_fifo #(.DEPTH(4), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .count      (count),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic o, input logic rdy);
    bus.in_valid    = v;
    bus.in_result   = r;
    bus.in_overflow = o;
    bus.out_ready   = rdy;
  endtask

  task automatic head(input string tag, input logic [31:0] d, input logic [2:0] f);
    check({tag, "_data"}, bus.out_data, d);
    check({tag, "_flags"}, {29'h0, bus.out_flags}, {29'h0, f});
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset state
    #2;
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    check("rst_count", {29'h0, count}, 32'h0);
    head("rst", 32'h0, 3'b000);
    check("rst_sticky", {31'h0, ovf_sticky}, 32'h0);
    check("rst_ovf_count", {30'h0, ovf_count}, 32'h0);
    #10 rst_n = 1'b1;
    cyc();
    check("rel_in_ready", {31'h0, bus.in_ready}, 32'h1);

    // T1: normal value, one-cycle latency
    drive(1'b1, 32'h3FC0_0000, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("t1_out_valid", {31'h0, bus.out_valid}, 32'h1);
    head("t1", 32'h3FC0_0000, 3'b000);
    check("t1_count", {29'h0, count}, 32'h1);
    check("t1_in_ready", {31'h0, bus.in_ready}, 32'h1);
    cyc();
    head("t1_hold", 32'h3FC0_0000, 3'b000);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    check("t1_drained", {29'h0, count}, 32'h0);

    // T2: overflow -> signed infinity
    drive(1'b1, 32'hC000_0000, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    head("t2", 32'hFF80_0000, 3'b010);
    check("t2_sticky", {31'h0, ovf_sticky}, 32'h1);
    check("t2_ovf_count", {30'h0, ovf_count}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    cyc();

    // T3: subnormal flush and signed zero, order preserved
    drive(1'b1, 32'h0000_0005, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("t3_count", {29'h0, count}, 32'h2);
    head("t3_first", 32'h0000_0000, 3'b101);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    head("t3_second", 32'h8000_0000, 3'b001);
    cyc();
    check("t3_empty", {31'h0, bus.out_valid}, 32'h0);

    // T4: fill to DEPTH, refused push at full, then streaming across the wrap
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b1, 32'h4000_0004, 1'b0, 1'b0);
    check("t4_full_count", {29'h0, count}, 32'h4);
    check("t4_full_in_ready", {31'h0, bus.in_ready}, 32'h0);
    cyc();
    check("t4_held_count", {29'h0, count}, 32'h4);
    head("t4_held", 32'h4000_0000, 3'b000);
    drive(1'b1, 32'h4000_0004, 1'b0, 1'b1);
    cyc();
    check("t4_pop_at_full_count", {29'h0, count}, 32'h3);
    head("t4_pop_at_full", 32'h4000_0001, 3'b000);
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b1);
      cyc();
      check($sformatf("t4_stream%0d_count", i), {29'h0, count}, 32'h3);
      head($sformatf("t4_stream%0d", i), 32'h4000_0000 + 32'(i - 2), 3'b000);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    head("t4_drain6", 32'h4000_0006, 3'b000);
    cyc();
    head("t4_drain7", 32'h4000_0007, 3'b000);
    cyc();
    check("t4_empty", {29'h0, count}, 32'h0);

    // T5: clear alone, saturation at 3, clear colliding with overflow push
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    clr_sticky = 1'b1;
    cyc();
    clr_sticky = 1'b0;
    check("t5_clr_sticky", {31'h0, ovf_sticky}, 32'h0);
    check("t5_clr_count", {30'h0, ovf_count}, 32'h0);
    drive(1'b1, 32'h0040_0000, 1'b1, 1'b1);
    cyc();
    head("t5_pos_inf", 32'h7F80_0000, 3'b010);
    drive(1'b1, 32'h4000_0000, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 32'h4000_0000, 1'b1, 1'b1);
    cyc();
    check("t5_count3", {30'h0, ovf_count}, 32'h3);
    drive(1'b1, 32'h4000_0000, 1'b1, 1'b1);
    cyc();
    check("t5_saturated", {30'h0, ovf_count}, 32'h3);
    drive(1'b0, 32'h4000_0000, 1'b1, 1'b1);
    cyc();
    check("t5_no_push_no_count", {30'h0, ovf_count}, 32'h3);
    drive(1'b1, 32'h4000_0000, 1'b1, 1'b1);
    clr_sticky = 1'b1;
    cyc();
    clr_sticky = 1'b0;
    check("t5_clr_push_sticky", {31'h0, ovf_sticky}, 32'h1);
    check("t5_clr_push_count", {30'h0, ovf_count}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    check("t5_empty", {29'h0, count}, 32'h0);

    // T6: asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3F00_0000 + 32'(i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("t6_count3", {29'h0, count}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("t6_rst_count", {29'h0, count}, 32'h0);
    check("t6_rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    head("t6_rst", 32'h0, 3'b000);
    #3 rst_n = 1'b1;
    cyc();
    check("t6_rel_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("t6_rel_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("t6_rel_sticky", {31'h0, ovf_sticky}, 32'h0);
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("t6_fresh_count", {29'h0, count}, 32'h1);
    head("t6_fresh", 32'h1234_5678, 3'b000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
